io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Parametrised successor to the single-port memory-mapped IO block.
- Provides NUM_PORTS independent DATA_W-bit output latches and synchronised input ports.
- Adds per-port sticky change detection, write-1-to-clear status, per-port interrupt enable and a registered read path.
- Sits on the CPU data bus; selected when io_access_addr[15]=1, in the same IO window as before.

Parameters:
- DATA_W, 16, width of each port and of the bus data.
- NUM_PORTS, 4, number of ports. Legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- io_access_addr  input  16  bus address, shared by read and write.
- io_in  input  DATA_W  write data from CPU.
- io_write_en  input  1  write strobe.
- io_read_en  input  1  read strobe.
- io_out  output  DATA_W  registered read data to CPU.
- io_read_device  input  NUM_PORTS*DATA_W  external inputs; port p occupies bits [p*DATA_W +: DATA_W]. Asynchronous to clk.
- io_write_device  output  NUM_PORTS*DATA_W  output latches, same packing as io_read_device.
- io_irq  output  1  OR over all ports of (chg[p] & ien[p]).

Behaviour:
- Decode:
  - sel = io_access_addr[15].
  - Port index p = io_access_addr[4:1].
  - Register type r = io_access_addr[0]: 0 = DATA, 1 = STATUS.
  - Bits [14:5] are ignored.
  - p >= NUM_PORTS: writes are ignored and reads return 0.
- Per-port state, all cleared by rst:
  - out_reg[DATA_W]; drives io_write_device directly (0 latency after the register).
  - s1, s2, s3, each DATA_W wide: synchroniser chain s1<=dev, s2<=s1, s3<=s2.
  - chg: sticky change flag.
  - ien: interrupt enable.
- Write (io_write_en & sel & p valid):
  - r=0: out_reg[p] <= io_in.
  - r=1: ien[p] <= io_in[1]; if io_in[0]=1, chg[p] is cleared (write-1-to-clear).
- Change set: chg[p] <= 1 on any edge where s2 != s3.
  - If a set and a W1C clear occur in the same cycle, set wins (chg stays 1).
- Timing of a device change that occurs before edge k:
  - Visible in s2 (DATA read) from edge k+1.
  - chg set at edge k+2.
- Read (io_read_en & sel):
  - Latency is 1: io_out is updated on the next edge.
  - r=0: io_out <= s2[p].
  - r=1: io_out <= {zeros, ien[p], chg[p]}, i.e. bit0 = chg and bit1 = ien, upper bits 0.
  - Reads have no side effects.
  - If the read condition is false, io_out <= 0.
- Read and write asserted in the same cycle are both performed. The read returns pre-write state (old chg/ien, old s2).
- DATA reads return the synchronised input, never out_reg.
- Reset:
  - io_out=0, io_write_device=0, io_irq=0, all chg/ien/s* =0.
  - Reset mid-operation discards pending read data and flags.
  - After reset, a device input already nonzero sets chg on edge 3 after rst deasserts. This is intended; software clears it during init.
- io_irq is combinational from the registered chg/ien, so it is glitch-free relative to clk.

Test Plan:
1. Reset, then write 0x1234 to addr 0x8002 (port1 DATA) → io_write_device[31:16]=0x1234 after the edge; other ports remain 0. Write to 0x0002 (bit15=0) → no change.
2. Drive io_read_device[15:0]=0xA5A5 before edge k. Read 0x8000 at edge k+1 → io_out=0xA5A5 one cycle later. A read at edge k returns 0.
3. Port2 input toggles. Read STATUS 0x8005 → io_out=0x0001 (chg=1, ien=0), io_irq=0. Write 0x0002 to 0x8005 → io_irq=1. Write 0x0003 → chg cleared, io_irq=0, ien stays 1.
4. W1C write to port0 STATUS in the same cycle that s2 != s3 → chg remains 1. Read in that same cycle returns the pre-write status.
5. NUM_PORTS=4: write to 0x8010 (p=8) → ignored. Read returns 0x0000. Assert rst while chg=1, ien=1 → io_irq=0, io_out=0 on the next edge.
6. Simultaneous io_read_en and io_write_en to 0x8006 (port3 DATA) with io_in=0xBEEF → io_write_device port3=0xBEEF; io_out = synchronised port3 input, not 0xBEEF.

Source files
------------

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS output latches and synchronised inputs with
// sticky per-port change flags, write-1-to-clear status and a registered read path.
module io_port_bank #(
  parameter int DATA_W    = 16,
  parameter int NUM_PORTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   io_access_addr,
  input  logic [DATA_W-1:0]             io_in,
  input  logic                          io_write_en,
  input  logic                          io_read_en,
  output logic [DATA_W-1:0]             io_out,
  input  logic [NUM_PORTS*DATA_W-1:0]   io_read_device,
  output logic [NUM_PORTS*DATA_W-1:0]   io_write_device,
  output logic                          io_irq
);

  logic       sel;
  logic [4:0] port_idx;
  logic       reg_sel;
  logic       port_ok;
  logic       wr_hit;
  logic       rd_hit;
  logic       unused_addr;

  logic [NUM_PORTS-1:0][DATA_W-1:0] out_q, out_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] s1_q, s2_q, s3_q;
  logic [NUM_PORTS-1:0]             chg_q, chg_d;
  logic [NUM_PORTS-1:0]             ien_q, ien_d;
  logic [DATA_W-1:0]                rd_q, rd_d;

  function automatic logic [DATA_W-1:0] status_word(input logic chg, input logic ien);
    logic [DATA_W-1:0] w;
    w    = '0;
    w[0] = chg;
    w[1] = ien;
    return w;
  endfunction

  assign sel         = io_access_addr[15];
  assign port_idx    = {1'b0, io_access_addr[4:1]};
  assign reg_sel     = io_access_addr[0];
  assign port_ok     = port_idx < 5'(NUM_PORTS);
  assign wr_hit      = io_write_en & sel & port_ok;
  assign rd_hit      = io_read_en & sel & port_ok;
  assign unused_addr = ^io_access_addr[14:5];

  // Reads sample pre-update state; a change detected this cycle beats a W1C clear.
  always_comb begin
    out_d = out_q;
    ien_d = ien_q;
    chg_d = chg_q;
    rd_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_idx == 5'(i)) begin
        if (wr_hit && !reg_sel) out_d[i] = io_in;
        if (wr_hit && reg_sel) begin
          ien_d[i] = io_in[1];
          if (io_in[0]) chg_d[i] = 1'b0;
        end
        if (rd_hit) rd_d = reg_sel ? status_word(chg_q[i], ien_q[i]) : s2_q[i];
      end
      if (s2_q[i] != s3_q[i]) chg_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      chg_q <= '0;
      ien_q <= '0;
      rd_q  <= '0;
    end else begin
      out_q <= out_d;
      s1_q  <= io_read_device;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      chg_q <= chg_d;
      ien_q <= ien_d;
      rd_q  <= rd_d;
    end
  end

  assign io_write_device = out_q;
  assign io_out          = rd_q;
  assign io_irq          = |(chg_q & ien_q);

endmodule

// File: tb/tb_io_port_bank.sv
// Directed table-driven bench for io_port_bank (DATA_W=16, NUM_PORTS=4).
module tb_io_port_bank;

  logic        clk;
  logic        rst;
  logic [15:0] io_access_addr;
  logic [15:0] io_in;
  logic        io_write_en;
  logic        io_read_en;
  logic [15:0] io_out;
  logic [63:0] io_read_device;
  logic [63:0] io_write_device;
  logic        io_irq;

  int total = 0;
  int bad   = 0;

  io_port_bank #(.DATA_W(16), .NUM_PORTS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .io_access_addr (io_access_addr),
    .io_in          (io_in),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_out         (io_out),
    .io_read_device (io_read_device),
    .io_write_device(io_write_device),
    .io_irq         (io_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        we;
    logic        re;
    logic [63:0] dev;
    logic [15:0] eo;
    logic [63:0] ew;
    logic        ei;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [15:0] addr, input logic [15:0] wd,
                              input logic we, input logic re, input logic [63:0] dev,
                              input logic [15:0] eo, input logic [63:0] ew, input logic ei);
    vec_t v;
    v.r = r; v.addr = addr; v.wd = wd; v.we = we; v.re = re; v.dev = dev;
    v.eo = eo; v.ew = ew; v.ei = ei;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, then check all outputs.
  task automatic step(input logic r, input logic [15:0] addr, input logic [15:0] wd,
                      input logic we, input logic re, input logic [63:0] dev,
                      input logic [15:0] eo, input logic [63:0] ew, input logic ei,
                      input string nm);
    @(negedge clk);
    rst            = r;
    io_access_addr = addr;
    io_in          = wd;
    io_write_en    = we;
    io_read_en     = re;
    io_read_device = dev;
    @(posedge clk);
    #1;
    total++;
    if (io_out !== eo) begin
      bad++;
      $display("FAIL %s io_out got=%h want=%h", nm, io_out, eo);
    end
    total++;
    if (io_write_device !== ew) begin
      bad++;
      $display("FAIL %s io_write_device got=%h want=%h", nm, io_write_device, ew);
    end
    total++;
    if (io_irq !== ei) begin
      bad++;
      $display("FAIL %s io_irq got=%b want=%b", nm, io_irq, ei);
    end
  endtask

  localparam logic [63:0] W1   = 64'h0000_0000_1234_0000;
  localparam logic [63:0] W2   = 64'hBEEF_0000_1234_0000;
  localparam logic [63:0] D0   = 64'h0000_0000_0000_A5A5;
  localparam logic [63:0] D1   = 64'h0000_0001_0000_A5A5;
  localparam logic [63:0] D2   = 64'h5A5A_0001_0000_A5A5;
  localparam logic [63:0] D3   = 64'h5A5A_0001_0000_0000;

  initial begin
    rst = 1'b1; io_access_addr = '0; io_in = '0; io_write_en = 1'b0;
    io_read_en = 1'b0; io_read_device = '0;

    //   rst  addr      wd       we    re    dev    exp_out  exp_wdev exp_irq
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 64'h0, 16'h0000, 64'h0, 1'b0); // reset
    add(1'b0, 16'h8002, 16'h1234, 1'b1, 1'b0, 64'h0, 16'h0000, W1,    1'b0); // port1 DATA write
    add(1'b0, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 64'h0, 16'h0000, W1,    1'b0); // unselected write
    add(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, D0,    16'h0000, W1,    1'b0); // read at edge k
    add(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, D0,    16'h0000, W1,    1'b0); // edge k+1, old s2
    add(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, D0,    16'hA5A5, W1,    1'b0); // edge k+2
    add(1'b0, 16'h8001, 16'h0000, 1'b0, 1'b1, D0,    16'h0001, W1,    1'b0); // status chg=1
    add(1'b0, 16'h8001, 16'h0001, 1'b1, 1'b1, D0,    16'h0001, W1,    1'b0); // W1C + read old
    add(1'b0, 16'h8001, 16'h0000, 1'b0, 1'b1, D0,    16'h0000, W1,    1'b0); // cleared
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D1,    16'h0000, W1,    1'b0); // port2 toggles
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D1,    16'h0000, W1,    1'b0);
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D1,    16'h0000, W1,    1'b0); // chg2 set
    add(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D1,    16'h0001, W1,    1'b0); // status port2
    add(1'b0, 16'h8005, 16'h0002, 1'b1, 1'b0, D1,    16'h0000, W1,    1'b1); // ien2=1 -> irq
    add(1'b0, 16'h8005, 16'h0003, 1'b1, 1'b0, D1,    16'h0000, W1,    1'b0); // clear chg2
    add(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D1,    16'h0002, W1,    1'b0); // ien stays 1
    add(1'b0, 16'h8010, 16'hDEAD, 1'b1, 1'b0, D1,    16'h0000, W1,    1'b0); // p=8 write ignored
    add(1'b0, 16'h8010, 16'h0000, 1'b0, 1'b1, D1,    16'h0000, W1,    1'b0); // p=8 read
    add(1'b0, 16'h8011, 16'h0000, 1'b0, 1'b1, D1,    16'h0000, W1,    1'b0); // p=8 status read
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D2,    16'h0000, W1,    1'b0); // port3 input change
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D2,    16'h0000, W1,    1'b0);
    add(1'b0, 16'h8006, 16'hBEEF, 1'b1, 1'b1, D2,    16'h5A5A, W2,    1'b0); // RMW port3 DATA

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].r, vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re, vecs[i].dev,
           vecs[i].eo, vecs[i].ew, vecs[i].ei, $sformatf("vec%0d", i));

    // W1C on port0 collides with a fresh change: set wins, read sees pre-write status.
    step(1'b0, 16'h8001, 16'h0002, 1'b1, 1'b0, D2, 16'h0000, W2, 1'b0, "ien0_set");
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D3, 16'h0000, W2, 1'b0, "p0_chg_k");
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, D3, 16'h0000, W2, 1'b0, "p0_chg_k1");
    step(1'b0, 16'h8001, 16'h0003, 1'b1, 1'b1, D3, 16'h0002, W2, 1'b1, "w1c_collide");
    step(1'b0, 16'h8001, 16'h0000, 1'b0, 1'b1, D3, 16'h0003, W2, 1'b1, "chg_kept");

    // Reset while chg/ien set and a read is pending.
    step(1'b1, 16'h8001, 16'h0000, 1'b0, 1'b1, D3, 16'h0000, 64'h0, 1'b0, "rst_mid");
    // Nonzero inputs after reset raise chg on the third edge.
    step(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D3, 16'h0000, 64'h0, 1'b0, "post_rst_e1");
    step(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D3, 16'h0000, 64'h0, 1'b0, "post_rst_e2");
    step(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D3, 16'h0000, 64'h0, 1'b0, "post_rst_e3");
    step(1'b0, 16'h8005, 16'h0000, 1'b0, 1'b1, D3, 16'h0001, 64'h0, 1'b0, "post_rst_e4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
